// File: rtl/switch_conditioner_pkg.sv
// Shared definitions for the switch conditioner.
//   ch_state_t : per-channel debounce state encoding
//   NUM_KEYS   : number of push-button channels
package switch_conditioner_pkg;

    localparam int NUM_KEYS = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHK_ON  = 2'd1,
        ON      = 2'd2,
        CHK_OFF = 2'd3
    } ch_state_t;

endpackage

// File: rtl/switch_conditioner_if.sv
// Key/pulse bundle of the switch conditioner.
//   key_in : raw push-button levels (1 = pressed), asynchronous
//   sw1..3 : one-cycle press pulses
//   level  : debounced key state per channel
// Modports: master drives keys (stimulus side), slave is the conditioner.
interface switch_conditioner_if;
    import switch_conditioner_pkg::*;

    logic [NUM_KEYS-1:0] key_in;
    logic                sw1;
    logic                sw2;
    logic                sw3;
    logic [NUM_KEYS-1:0] level;

    modport master (output key_in, input sw1, sw2, sw3, level);
    modport slave  (input key_in, output sw1, sw2, sw3, level);
endinterface

// File: rtl/switch_conditioner_debounce_channel.sv
// One push-button channel: two-flop synchronizer, debounce FSM, stability counter.
//   clk, rst : system clock, synchronous active-high reset
//   key      : raw asynchronous key level
//   level    : registered debounced state
//   accept   : combinational strobe, high in the cycle whose edge accepts a press
//
// state   | meaning
// IDLE    | key released, waiting for a synchronized 1
// CHK_ON  | key seen high, counting stable high samples
// ON      | press accepted, level=1
// CHK_OFF | key seen low, counting stable low samples
module debounce_channel
    import switch_conditioner_pkg::*;
#(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic level,
    output logic accept
);

    localparam int          CW   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

    logic          s1;
    logic          s2;
    ch_state_t     state;
    logic [CW-1:0] cnt;

    // Raised on the same edge that moves CHK_ON to ON, so the arbiter
    // registers the pending bit together with level.
    assign accept = (state == CHK_ON) && s2 && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            state <= IDLE;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            s1 <= key;
            s2 <= s1;
            case (state)
                IDLE: begin
                    if (s2) begin
                        state <= CHK_ON;
                        cnt   <= '0;
                    end
                end
                CHK_ON: begin
                    if (!s2) begin
                        state <= IDLE;
                    end else if (cnt == LAST) begin
                        state <= ON;
                        level <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ON: begin
                    if (!s2) begin
                        state <= CHK_OFF;
                        cnt   <= '0;
                    end
                end
                CHK_OFF: begin
                    if (s2) begin
                        state <= ON;
                    end else if (cnt == LAST) begin
                        state <= IDLE;
                        level <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/switch_conditioner.sv
// Push-button conditioner: three debounced channels feeding a pending-press
// queue that emits at most one press pulse per cycle, lowest index first.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : key_in in, sw1/sw2/sw3 pulses and level out
module switch_conditioner
    import switch_conditioner_pkg::*;
#(
    parameter int DB_CYCLES = 4
) (
    input logic                 clk,
    input logic                 rst,
    switch_conditioner_if.slave bus
);

    logic [NUM_KEYS-1:0] accept;
    logic [NUM_KEYS-1:0] level_w;
    logic [NUM_KEYS-1:0] pending;
    logic [NUM_KEYS-1:0] grant;
    logic [NUM_KEYS-1:0] sw_q;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        debounce_channel #(.DB_CYCLES(DB_CYCLES)) u_ch (
            .clk    (clk),
            .rst    (rst),
            .key    (bus.key_in[i]),
            .level  (level_w[i]),
            .accept (accept[i])
        );
    end

    // Fixed priority: lowest pending index wins.
    always_comb begin
        grant = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (pending[i]) grant = '0;
            if (pending[i]) grant[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            sw_q    <= '0;
        end else begin
            sw_q    <= grant;
            // A press accepted while another bit is emitted stays queued.
            pending <= (pending & ~grant) | accept;
        end
    end

    assign bus.sw1   = sw_q[0];
    assign bus.sw2   = sw_q[1];
    assign bus.sw3   = sw_q[2];
    assign bus.level = level_w;

endmodule

// File: tb/tb_switch_conditioner.sv
// Directed bench for switch_conditioner with DB_CYCLES=4: clean press, glitch,
// bounce, simultaneous press, reset mid-debounce, held key with release glitch.
module tb_switch_conditioner;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    switch_conditioner_if bus ();

    switch_conditioner #(.DB_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        bus.key_in = 3'b000;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_cmp++;
        if ({bus.sw3, bus.sw2, bus.sw1} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_sw got=%b want=000", {bus.sw3, bus.sw2, bus.sw1});
        end
        n_cmp++;
        if (bus.level !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_level got=%b want=000", bus.level);
        end
        idle(3);
    endtask

    task automatic test_clean_press();
        int pulses = 0;
        bus.key_in[0] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            if (bus.sw1) pulses++;
            n_cmp++;
            if (bus.sw1 !== (c == 7)) begin
                n_bad++;
                $display("FAIL press_sw1 c=%0d got=%b want=%b", c, bus.sw1, (c == 7));
            end
            n_cmp++;
            if (bus.level[0] !== (c >= 6)) begin
                n_bad++;
                $display("FAIL press_level c=%0d got=%b want=%b", c, bus.level[0], (c >= 6));
            end
        end
        bus.key_in[0] = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (bus.sw1) pulses++;
            n_cmp++;
            if (bus.level[0] !== (c < 6)) begin
                n_bad++;
                $display("FAIL release_level c=%0d got=%b want=%b", c, bus.level[0], (c < 6));
            end
        end
        n_cmp++;
        if (pulses != 1) begin
            n_bad++;
            $display("FAIL press_count got=%0d want=1", pulses);
        end
    endtask

    task automatic test_glitch();
        int seen_sw = 0;
        int seen_lv = 0;
        bus.key_in[1] = 1'b1;
        step();
        step();
        bus.key_in[1] = 1'b0;
        for (int c = 0; c < 15; c++) begin
            step();
            if (bus.sw2) seen_sw++;
            if (bus.level[1]) seen_lv++;
        end
        n_cmp++;
        if (seen_sw != 0) begin
            n_bad++;
            $display("FAIL glitch_sw2 got=%0d pulses want=0", seen_sw);
        end
        n_cmp++;
        if (seen_lv != 0) begin
            n_bad++;
            $display("FAIL glitch_level got=%0d high cycles want=0", seen_lv);
        end
    endtask

    task automatic test_bounce();
        int pulses = 0;
        for (int i = 0; i < 6; i++) begin
            bus.key_in[2] = (i % 2 == 0);
            step();
            if (bus.sw3) pulses++;
        end
        bus.key_in[2] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            if (bus.sw3) pulses++;
            n_cmp++;
            if (bus.sw3 !== (c == 7)) begin
                n_bad++;
                $display("FAIL bounce_sw3 c=%0d got=%b want=%b", c, bus.sw3, (c == 7));
            end
        end
        n_cmp++;
        if (pulses != 1) begin
            n_bad++;
            $display("FAIL bounce_count got=%0d want=1", pulses);
        end
        bus.key_in[2] = 1'b0;
        idle(12);
    endtask

    task automatic test_simultaneous();
        logic [2:0] exp;
        int multi = 0;
        bus.key_in = 3'b111;
        for (int c = 0; c < 15; c++) begin
            step();
            exp = (c == 7) ? 3'b001 : (c == 8) ? 3'b010 : (c == 9) ? 3'b100 : 3'b000;
            if (int'(bus.sw1) + int'(bus.sw2) + int'(bus.sw3) > 1) multi++;
            n_cmp++;
            if ({bus.sw3, bus.sw2, bus.sw1} !== exp) begin
                n_bad++;
                $display("FAIL simul_sw c=%0d got=%b want=%b", c, {bus.sw3, bus.sw2, bus.sw1}, exp);
            end
        end
        n_cmp++;
        if (multi != 0) begin
            n_bad++;
            $display("FAIL simul_overlap got=%0d cycles want=0", multi);
        end
        bus.key_in = 3'b000;
        idle(12);
        n_cmp++;
        if (bus.level !== 3'b000) begin
            n_bad++;
            $display("FAIL simul_release_level got=%b want=000", bus.level);
        end
    endtask

    task automatic test_reset_mid_debounce();
        int pulses = 0;
        bus.key_in[0] = 1'b1;
        idle(3);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if ({bus.sw3, bus.sw2, bus.sw1} !== 3'b000 || bus.level !== 3'b000) begin
                n_bad++;
                $display("FAIL rstmid_during got sw=%b level=%b want 000/000",
                         {bus.sw3, bus.sw2, bus.sw1}, bus.level);
            end
        end
        rst = 1'b0;
        for (int c = 0; c < 15; c++) begin
            step();
            if (bus.sw1) pulses++;
            n_cmp++;
            if (bus.sw1 !== (c == 7)) begin
                n_bad++;
                $display("FAIL rstmid_sw1 c=%0d got=%b want=%b", c, bus.sw1, (c == 7));
            end
        end
        n_cmp++;
        if (pulses != 1) begin
            n_bad++;
            $display("FAIL rstmid_count got=%0d want=1", pulses);
        end
        bus.key_in[0] = 1'b0;
        idle(12);
    endtask

    task automatic test_held_release();
        int pulses = 0;
        bus.key_in[0] = 1'b1;
        for (int c = 0; c < 50; c++) begin
            step();
            if (bus.sw1) pulses++;
        end
        // Release, then a single-cycle high glitch two cycles later.
        bus.key_in[0] = 1'b0;
        for (int c = 0; c < 20; c++) begin
            bus.key_in[0] = (c == 2);
            step();
            if (bus.sw1) pulses++;
            if (c == 8) begin
                n_cmp++;
                if (bus.level[0] !== 1'b1) begin
                    n_bad++;
                    $display("FAIL held_level_g8 got=%b want=1", bus.level[0]);
                end
            end
            if (c == 9) begin
                n_cmp++;
                if (bus.level[0] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL held_level_g9 got=%b want=0", bus.level[0]);
                end
            end
        end
        n_cmp++;
        if (pulses != 1) begin
            n_bad++;
            $display("FAIL held_count got=%0d want=1", pulses);
        end
        n_cmp++;
        if (bus.level[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL held_final_level got=%b want=0", bus.level[0]);
        end
    endtask

    initial begin
        bus.key_in = 3'b000;
        test_reset();
        test_clean_press();
        test_glitch();
        test_bounce();
        test_simultaneous();
        test_reset_mid_debounce();
        test_held_release();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
